// File: rtl/ddr2_pkg.sv
// Shared DDR2 capture-path definitions: packer FSM states, burst geometry and lane width.
package ddr2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int unsigned BURST_WORDS     = 16;
  localparam int unsigned LANE_W          = 16;
  // Controller burst length in 32-bit beats
  localparam int unsigned DDR_BURST_BEATS = BURST_WORDS * 2;

endpackage

// File: rtl/sample_decimator.sv
// Sample qualifier for the packer: passes every (decim+1)-th valid sample.
// Instantiated by ddr2_sample_packer only when SAMPLE_PACKER_DECIM_EN is defined.
module sample_decimator
  import ddr2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       sample_valid,
  input  logic [7:0] decim,
  output logic       accept
);

  logic [7:0] cnt;

  assign accept = sample_valid && (cnt == decim);

  // cnt holds the number of valid samples skipped since the last accepted one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (sample_valid) begin
      cnt <= accept ? '0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ddr2_sample_packer.sv
// Packs 16-bit samples four-per-word into the DDR2 input FIFO, padding aborted records to whole bursts.
// Optional decimation of the sample stream with SAMPLE_PACKER_DECIM_EN.
module ddr2_sample_packer
  import ddr2_pkg::*;
#(
  parameter int unsigned BURST_WORDS = ddr2_pkg::BURST_WORDS,
  parameter int unsigned LEN_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [LEN_W-1:0]  record_bursts,
  input  logic [15:0]       sample_in,
  input  logic              sample_valid,
`ifdef SAMPLE_PACKER_DECIM_EN
  input  logic [7:0]        decim,
`endif
  output logic              ib_we,
  output logic [63:0]       ib_wdata,
  input  logic              ib_full,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [LEN_W+3:0]  words_written
);

  localparam int unsigned CW = LEN_W + 4;
  typedef logic [CW-1:0] cnt_t;

  state_t                 state;
  logic [1:0]             lane;
  logic [3*LANE_W-1:0]    lane_buf;
  logic [63:0]            out_reg;
  logic                   pending;
  logic                   flush_part;
  cnt_t                   target;

  logic                   accept;
  logic                   take;
  logic                   pending_eff;
  logic                   word_done;
  logic [1:0]             lane_nxt;
  logic [3*LANE_W-1:0]    buf_nxt;
  logic [63:0]            word_nxt;
  cnt_t                   ww_nxt;
  cnt_t                   queued;

`ifdef SAMPLE_PACKER_DECIM_EN
  sample_decimator u_decim (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart      ((state == ST_ARMED) && sample_valid && trigger),
    .sample_valid ((state == ST_CAPTURE) && sample_valid),
    .decim        (decim),
    .accept       (accept)
  );
`else
  assign accept = sample_valid;
`endif

  assign ib_we       = pending && !ib_full;
  assign ib_wdata    = out_reg;
  assign busy        = state inside {ST_ARMED, ST_CAPTURE, ST_FLUSH};
  assign pending_eff = pending && !ib_we;
  assign ww_nxt      = words_written + cnt_t'(ib_we);
  assign queued      = words_written + cnt_t'(pending);
  // Once every word of the record is written or queued, later samples are ignored
  assign take        = (state == ST_CAPTURE) && accept && (queued != target);

  always_comb begin
    word_done = take && (lane == 2'd3);
    word_nxt  = {sample_in, lane_buf};
    lane_nxt  = take ? lane + 2'd1 : lane;
    buf_nxt   = lane_buf;
    if (take) begin
      if (lane == 2'd3) buf_nxt = '0;
      else              buf_nxt[lane*LANE_W +: LANE_W] = sample_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      lane          <= '0;
      lane_buf      <= '0;
      out_reg       <= '0;
      pending       <= 1'b0;
      flush_part    <= 1'b0;
      target        <= '0;
      overflow      <= 1'b0;
      words_written <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ib_we) begin
        pending       <= 1'b0;
        words_written <= ww_nxt;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            target        <= cnt_t'(record_bursts) * cnt_t'(BURST_WORDS);
            lane          <= '0;
            lane_buf      <= '0;
            pending       <= 1'b0;
            flush_part    <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
            if (record_bursts == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (sample_valid && trigger) begin
            lane_buf <= {{(2*LANE_W){1'b0}}, sample_in};
            lane     <= 2'd1;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          lane     <= lane_nxt;
          lane_buf <= buf_nxt;
          if (word_done) begin
            if (pending_eff) begin
              overflow <= 1'b1;
            end else begin
              out_reg <= word_nxt;
              pending <= 1'b1;
            end
          end
          if (ib_we && (ww_nxt == target)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (abort) begin
            flush_part <= (lane_nxt != 2'd0);
            state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Output register frees up: queue the partial word first, then zero pad
          if (!pending_eff) begin
            if (flush_part) begin
              out_reg    <= {{LANE_W{1'b0}}, lane_buf};
              pending    <= 1'b1;
              flush_part <= 1'b0;
              lane       <= '0;
              lane_buf   <= '0;
            end else if ((ww_nxt % cnt_t'(BURST_WORDS)) != '0) begin
              out_reg <= '0;
              pending <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
